// File: rtl/wishbone_bus_if.sv
// wishbone_bus_if
// Bridges the OpenMIPS data-memory port (ce/we/addr/sel/data) onto a
// Wishbone B4 classic single-transfer master. The bridge holds the pipeline
// with stallreq until the slave acknowledges. It keeps read data available
// while other stages keep the pipeline frozen.
//
// Ports
//   clk, rst          system clock; synchronous active-high reset
//   stall_i           pipeline stall vector (nonzero = frozen)
//   flush_i           pipeline flush, aborts any in-flight transfer
//   cpu_ce_i/we_i     CPU transfer request / direction (1 = write)
//   cpu_addr_i        byte address
//   cpu_sel_i         byte lane enables (passed through unmodified)
//   cpu_data_i        write data
//   cpu_data_o        read data to MEM stage (combinational)
//   stallreq          stall request to ctrl (combinational)
//   wb_ack_i, wb_data_i              slave acknowledge / read data
//   wb_addr_o .. wb_cyc_o            registered Wishbone master outputs
//
// state          | meaning
// IDLE           | no transfer; a CPU request launches one
// BUSY           | stb/cyc asserted, waiting for slave ack
// WAIT_FOR_STALL | transfer done, pipeline still frozen; serve rd_buf
module wishbone_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall_i,
  input  logic                flush_i,
  input  logic                cpu_ce_i,
  input  logic                cpu_we_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W/8-1:0] cpu_sel_i,
  input  logic [DATA_W-1:0]   cpu_data_i,
  output logic [DATA_W-1:0]   cpu_data_o,
  output logic                stallreq,
  input  logic                wb_ack_i,
  input  logic [DATA_W-1:0]   wb_data_i,
  output logic [ADDR_W-1:0]   wb_addr_o,
  output logic [DATA_W-1:0]   wb_data_o,
  output logic                wb_we_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic                wb_stb_o,
  output logic                wb_cyc_o
);

  localparam int SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    BUSY           = 2'd1,
    WAIT_FOR_STALL = 2'd2
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   wb_addr_q;
  logic [DATA_W-1:0]   wb_data_q;
  logic                wb_we_q;
  logic [SEL_W-1:0]    wb_sel_q;
  logic                wb_stb_q;
  logic [DATA_W-1:0]   rd_buf_q;

  logic                stalled;

  assign stalled = (stall_i != 6'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_we_q   <= 1'b0;
      wb_sel_q  <= '0;
      wb_stb_q  <= 1'b0;
      rd_buf_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_ce_i && !flush_i) begin
            wb_addr_q <= cpu_addr_i;
            wb_data_q <= cpu_data_i;
            wb_we_q   <= cpu_we_i;
            wb_sel_q  <= cpu_sel_i;
            wb_stb_q  <= 1'b1;
            rd_buf_q  <= '0;
            state_q   <= BUSY;
          end else begin
            wb_addr_q <= '0;
            wb_data_q <= '0;
            wb_we_q   <= 1'b0;
            wb_sel_q  <= '0;
            wb_stb_q  <= 1'b0;
          end
        end

        BUSY: begin
          if (flush_i) begin
            // Abort wins over a coincident ack; the result is discarded.
            wb_addr_q <= '0;
            wb_data_q <= '0;
            wb_we_q   <= 1'b0;
            wb_sel_q  <= '0;
            wb_stb_q  <= 1'b0;
            rd_buf_q  <= '0;
            state_q   <= IDLE;
          end else if (wb_ack_i) begin
            wb_addr_q <= '0;
            wb_data_q <= '0;
            wb_we_q   <= 1'b0;
            wb_sel_q  <= '0;
            wb_stb_q  <= 1'b0;
            if (!wb_we_q) begin
              rd_buf_q <= wb_data_i;
            end
            // Parking here while frozen keeps a held ce from re-issuing.
            state_q <= stalled ? WAIT_FOR_STALL : IDLE;
          end
        end

        WAIT_FOR_STALL: begin
          wb_addr_q <= '0;
          wb_data_q <= '0;
          wb_we_q   <= 1'b0;
          wb_sel_q  <= '0;
          wb_stb_q  <= 1'b0;
          if (flush_i) begin
            rd_buf_q <= '0;
            state_q  <= IDLE;
          end else if (!stalled) begin
            state_q <= IDLE;
          end
        end

        default: begin
          wb_addr_q <= '0;
          wb_data_q <= '0;
          wb_we_q   <= 1'b0;
          wb_sel_q  <= '0;
          wb_stb_q  <= 1'b0;
          rd_buf_q  <= '0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stallreq   = 1'b0;
    cpu_data_o = '0;
    case (state_q)
      IDLE: begin
        stallreq = cpu_ce_i & ~flush_i;
      end
      BUSY: begin
        if (flush_i) begin
          stallreq = 1'b0;
        end else if (wb_ack_i) begin
          // Same-cycle bypass so a zero-wait read costs one stall cycle.
          stallreq   = 1'b0;
          cpu_data_o = wb_we_q ? '0 : wb_data_i;
        end else begin
          stallreq = 1'b1;
        end
      end
      WAIT_FOR_STALL: begin
        cpu_data_o = rd_buf_q;
      end
      default: begin
        stallreq   = 1'b0;
        cpu_data_o = '0;
      end
    endcase
  end

  assign wb_addr_o = wb_addr_q;
  assign wb_data_o = wb_data_q;
  assign wb_we_o   = wb_we_q;
  assign wb_sel_o  = wb_sel_q;
  assign wb_stb_o  = wb_stb_q;
  assign wb_cyc_o  = wb_stb_q;

endmodule

// File: tb/tb_wishbone_bus_if.sv
module tb_wishbone_bus_if;

  logic        clk;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        cpu_ce_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_i;
  logic [31:0] cpu_data_o;
  logic        stallreq;
  logic        wb_ack_i;
  logic [31:0] wb_data_i;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];

  wishbone_bus_if #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_sel_i  (cpu_sel_i),
    .cpu_data_i (cpu_data_i),
    .cpu_data_o (cpu_data_o),
    .stallreq   (stallreq),
    .wb_ack_i   (wb_ack_i),
    .wb_data_i  (wb_data_i),
    .wb_addr_o  (wb_addr_o),
    .wb_data_o  (wb_data_o),
    .wb_we_o    (wb_we_o),
    .wb_sel_o   (wb_sel_o),
    .wb_stb_o   (wb_stb_o),
    .wb_cyc_o   (wb_cyc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a completed transfer is presented as stb & ack without flush.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && wb_stb_o && wb_ack_i && !flush_i) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected: got transfer addr %h required none", wb_addr_o);
        end else begin
          e = sb_q.pop_front();
          chk("mon_addr", wb_addr_o, e.addr);
          chk("mon_we", {31'd0, wb_we_o}, {31'd0, e.we});
          chk("mon_sel", {28'd0, wb_sel_o}, {28'd0, e.sel});
          chk("mon_wdata", wb_data_o, e.wdata);
          chk("mon_cyc", {31'd0, wb_cyc_o}, 32'd1);
          chk("mon_cpu_data", cpu_data_o, e.rdata);
          chk("mon_stallreq", {31'd0, stallreq}, 32'd0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_stb"}, {31'd0, wb_stb_o}, 32'd0);
    chk({tag, "_cyc"}, {31'd0, wb_cyc_o}, 32'd0);
    chk({tag, "_addr"}, wb_addr_o, 32'd0);
    chk({tag, "_wdata"}, wb_data_o, 32'd0);
    chk({tag, "_we_sel"}, {27'd0, wb_we_o, wb_sel_o}, 32'd0);
    chk({tag, "_stallreq"}, {31'd0, stallreq}, 32'd0);
    chk({tag, "_cpu_data"}, cpu_data_o, 32'd0);
    step();
  endtask

  // One transfer starting from IDLE. waits = slave wait states,
  // hold = cycles stall_i stays nonzero after the ack cycle.
  task automatic do_xfer(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] wdata, input int waits,
                         input logic [31:0] rdata, input int hold);
    exp_t e;
    int   sreq;
    cpu_ce_i   = 1'b1;
    cpu_we_i   = we;
    cpu_addr_i = addr;
    cpu_sel_i  = sel;
    cpu_data_i = wdata;
    stall_i    = 6'd0;
    wb_ack_i   = 1'b0;
    e.addr  = addr;
    e.we    = we;
    e.sel   = sel;
    e.wdata = wdata;
    e.rdata = we ? 32'd0 : rdata;
    sb_q.push_back(e);
    @(negedge clk);
    chk("req_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("req_stallreq", {31'd0, stallreq}, 32'd1);
    sreq = 1;
    step();
    for (int i = 0; i <= waits; i++) begin
      wb_ack_i  = (i == waits);
      wb_data_i = (i == waits) ? rdata : 32'hBAD0_0000 + i;
      stall_i   = (i == waits && hold > 0) ? 6'b000011 : 6'd0;
      @(negedge clk);
      chk("busy_stb", {31'd0, wb_stb_o}, 32'd1);
      chk("busy_addr", wb_addr_o, addr);
      chk("busy_wdata", wb_data_o, wdata);
      chk("busy_we_sel", {27'd0, wb_we_o, wb_sel_o}, {27'd0, we, sel});
      if (i < waits) chk("busy_cpu_data", cpu_data_o, 32'd0);
      if (stallreq) sreq++;
      step();
    end
    chk("stallreq_cycles", sreq, waits + 1);
    wb_ack_i  = 1'b0;
    wb_data_i = 32'hBAD0_FFFF;
    if (hold > 0) begin
      for (int j = 0; j <= hold; j++) begin
        stall_i = (j < hold) ? 6'b000011 : 6'd0;
        @(negedge clk);
        chk("wait_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("wait_stallreq", {31'd0, stallreq}, 32'd0);
        chk("wait_cpu_data", cpu_data_o, e.rdata);
        step();
      end
    end
    stall_i  = 6'd0;
    cpu_ce_i = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    stall_i    = 6'd0;
    flush_i    = 1'b0;
    cpu_ce_i   = 1'b0;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'd0;
    cpu_sel_i  = 4'd0;
    cpu_data_i = 32'd0;
    wb_ack_i   = 1'b0;
    wb_data_i  = 32'd0;
    step();
    check_idle("reset");
    rst = 1'b0;

    // Zero-wait read
    do_xfer(1'b0, 32'h0000_0010, 4'hF, 32'h0, 0, 32'h1234_5678, 0);
    check_idle("after_rd0");

    // Write with 3 wait states; read data on the bus must not leak
    do_xfer(1'b1, 32'h0000_0020, 4'b0011, 32'hAABB_CCDD, 3, 32'h5555_AAAA, 0);
    check_idle("after_wr3");

    // Read completing under an external stall
    do_xfer(1'b0, 32'h0000_0030, 4'hF, 32'h0, 1, 32'hDEAD_BEEF, 3);
    check_idle("after_stall");

    // Flush in the 2nd BUSY cycle, followed by a late ack
    cpu_ce_i   = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h0000_0040;
    cpu_sel_i  = 4'hF;
    step();
    @(negedge clk);
    chk("flush_busy1_stallreq", {31'd0, stallreq}, 32'd1);
    step();
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_stallreq", {31'd0, stallreq}, 32'd0);
    step();
    flush_i   = 1'b0;
    cpu_ce_i  = 1'b0;
    wb_ack_i  = 1'b1;
    wb_data_i = 32'hCAFE_F00D;
    check_idle("flush_late_ack0");
    check_idle("flush_late_ack1");
    wb_ack_i = 1'b0;

    // Reset while BUSY
    cpu_ce_i   = 1'b1;
    cpu_we_i   = 1'b1;
    cpu_addr_i = 32'h0000_0050;
    cpu_sel_i  = 4'hC;
    cpu_data_i = 32'h1122_3344;
    step();
    @(negedge clk);
    chk("rst_busy_stb", {31'd0, wb_stb_o}, 32'd1);
    step();
    rst = 1'b1;
    step();
    rst      = 1'b0;
    cpu_ce_i = 1'b0;
    check_idle("after_rst");

    // Back-to-back reads; the second request cycle is the idle gap
    do_xfer(1'b0, 32'h0000_0000, 4'hF, 32'h0, 0, 32'h0000_0001, 0);
    do_xfer(1'b0, 32'h0000_0004, 4'hF, 32'h0, 0, 32'h0000_0002, 0);
    check_idle("after_b2b");

    // Request coincident with flush in IDLE must not start a transfer
    cpu_ce_i = 1'b1;
    flush_i  = 1'b1;
    @(negedge clk);
    chk("idle_flush_stallreq", {31'd0, stallreq}, 32'd0);
    step();
    cpu_ce_i = 1'b0;
    flush_i  = 1'b0;
    check_idle("after_idle_flush");

    repeat (3) step();
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wishbone_bus_if.md
# wishbone_bus_if

Bridges the OpenMIPS data-memory port (ce/we/addr/sel/data) onto a Wishbone B4 classic master interface, so data_ram can be replaced by any Wishbone slave with variable latency. It sits between the processor's ram_* port and the memory/bus fabric in the SOPC. It raises a pipeline stall request until the slave acknowledges. It holds read data across pipeline stalls imposed by other stages.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; sel width is DATA_W/8

- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- stall_i  in  6  pipeline stall vector from ctrl; nonzero = pipeline frozen
- flush_i  in  1  pipeline flush (exception); aborts any in-flight transfer
- cpu_ce_i  in  1  CPU requests a transfer
- cpu_we_i  in  1  1 = write, 0 = read
- cpu_addr_i  in  ADDR_W  byte address
- cpu_sel_i  in  DATA_W/8  byte lane enables
- cpu_data_i  in  DATA_W  write data
- cpu_data_o  out  DATA_W  read data to MEM stage (combinational)
- stallreq  out  1  stall request to ctrl (combinational)
- wb_ack_i  in  1  slave acknowledge
- wb_data_i  in  DATA_W  slave read data
- wb_addr_o  out  ADDR_W  registered
- wb_data_o  out  DATA_W  registered
- wb_we_o  out  1  registered
- wb_sel_o  out  DATA_W/8  registered
- wb_stb_o  out  1  registered
- wb_cyc_o  out  1  registered

## Operation
- States: IDLE, BUSY, WAIT_FOR_STALL. Reset → IDLE.
- Reset: all wb_*_o = 0, rd_buf = 0, state IDLE. Reset has priority in every state, including mid-transfer; stb/cyc drop on the next edge.
- IDLE, cpu_ce_i=1 and flush_i=0: latch addr/data/we/sel onto wb_*_o, set stb=cyc=1, clear rd_buf, → BUSY. Otherwise hold all outputs at 0.
- BUSY, flush_i=1: clear stb/cyc/addr/data/we/sel, clear rd_buf, → IDLE. A coincident ack is ignored.
- BUSY, wb_ack_i=1 (no flush):
  - Clear all wb_*_o.
  - On a read (wb_we_o=0), rd_buf ← wb_data_i.
  - Next state: WAIT_FOR_STALL if stall_i≠0, else IDLE.
- BUSY, no ack: hold all wb_*_o stable (Wishbone rule).
- WAIT_FOR_STALL: wb_*_o = 0. → IDLE when stall_i == 0. flush_i=1 → IDLE and clears rd_buf.
- Combinational outputs:
  - IDLE: stallreq = cpu_ce_i & ~flush_i; cpu_data_o = 0.
  - BUSY: with ack, stallreq = 0 and cpu_data_o = wb_we_o ? 0 : wb_data_i (same-cycle bypass). Without ack, stallreq = 1 and cpu_data_o = 0. With flush, stallreq = 0.
  - WAIT_FOR_STALL: stallreq = 0; cpu_data_o = rd_buf.
- Sel/data pass through unmodified. Byte-lane alignment is the MEM stage's job.
- One outstanding transfer only. No burst, no cti/bte, err/rty not supported.

## Timing
- Request seen in IDLE at edge N: stb/cyc high after edge N; stallreq high from the cycle of the request.
- Zero-wait slave (ack in first BUSY cycle): stallreq deasserts in that cycle. Total pipeline stall = 1 cycle. Read data appears on cpu_data_o in the ack cycle.
- Slave with k wait states: stallreq high for k+1 cycles.
- After ack, the bridge returns to IDLE on the next edge. A new request that cycle starts a new transfer: back-to-back spacing is 1 idle cycle minimum.
- A request held by a stalled pipeline after completion must not re-issue. WAIT_FOR_STALL guarantees this: the bridge stays there until stall_i clears.
- wb_stb_o and wb_cyc_o are always equal.

## Test plan
- Read, zero-wait: addr=0x0000_0010, we=0, slave acks in the first BUSY cycle with 0x1234_5678. Required: stb high 1 cycle; stallreq 1 cycle; cpu_data_o = 0x1234_5678 in the ack cycle; state → IDLE.
- Write, 3 wait states: addr=0x20, sel=4'b0011, data=0xAABB_CCDD. Required: wb_* stable for 4 cycles; stallreq 4 cycles; cpu_data_o = 0; outputs cleared after ack.
- Read with external stall: ack with 0xDEAD_BEEF while stall_i=6'b000011 for 3 more cycles. Required: state WAIT_FOR_STALL; cpu_data_o = 0xDEAD_BEEF each cycle; no new stb; IDLE once stall_i=0.
- Flush mid-transfer: flush_i=1 in the 2nd BUSY cycle. Required: stb/cyc 0 next cycle; stallreq 0 in the flush cycle; rd_buf = 0; a later ack is ignored.
- Reset mid-transfer: rst=1 while BUSY. Required: all wb_*_o = 0 and state IDLE after the edge; stallreq = 0 once cpu_ce_i=0.
- Back-to-back reads at 0x0 and 0x4, ack each with 0x1 and 0x2. Required: two distinct stb pulses separated by ≥1 idle cycle; returned data 0x1 then 0x2.
